// File: rtl/shared_vc_credit_tracker.sv
// Transmit-side shared-VC credit tracker: round-robin ownership of the downstream shared buffer plus credit counting.
// Optional SHARED_CREDIT_BYPASS_EN lets a credit arriving at count 0 make shared_avail rise in the same cycle.
module shared_vc_credit_tracker #(
    parameter int num_vcs            = 4,
    parameter int shared_buffer_size = 8,
    localparam int vc_idx_width      = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int cnt_width         = $clog2(shared_buffer_size + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [num_vcs-1:0]   alloc_req,
    input  logic                 bank_grant_in,
    input  logic                 flit_valid,
    input  logic                 flit_tail,
    input  logic                 credit_for_shared_in,
    output logic                 bank_req_out,
    output logic [num_vcs-1:0]   alloc_gnt,
    output logic                 shared_vc_out,
    output logic                 shared_avail,
    output logic [cnt_width-1:0] credit_count,
    output logic                 error
);

    typedef enum logic [1:0] {IDLE, REQ, OWNED, DRAIN} state_t;

    localparam logic [cnt_width-1:0] full_count = cnt_width'(shared_buffer_size);

    state_t                  state_q, state_d;
    logic [vc_idx_width-1:0] ptr_q, ptr_d;
    logic [vc_idx_width-1:0] winner_q, winner_d;
    logic [vc_idx_width-1:0] rr_pick, scan_idx;
    logic                    rr_found;
    logic [cnt_width-1:0]    count_q, count_d;
    logic                    error_q, error_d;
    logic                    underflow, overflow, stray_flit, stray_grant;

    // Saturating credit update: a flit and a credit in the same cycle cancel out.
    function automatic logic [cnt_width-1:0] credit_next(input logic [cnt_width-1:0] cnt,
                                                         input logic take,
                                                         input logic give);
        if (take && !give)
            return (cnt == '0) ? cnt : cnt - 1'b1;
        if (give && !take)
            return (cnt == full_count) ? cnt : cnt + 1'b1;
        return cnt;
    endfunction

    assign count_d = credit_next(count_q, flit_valid, credit_for_shared_in);

    always_comb begin
        rr_pick  = ptr_q;
        rr_found = 1'b0;
        scan_idx = ptr_q;
        for (int k = 0; k < num_vcs; k++) begin
            scan_idx = vc_idx_width'((int'(ptr_q) + k) % num_vcs);
            if (!rr_found && alloc_req[scan_idx]) begin
                rr_pick  = scan_idx;
                rr_found = 1'b1;
            end
        end
    end

    assign underflow   = flit_valid && !credit_for_shared_in && (count_q == '0);
    assign overflow    = credit_for_shared_in && !flit_valid && (count_q == full_count);
    assign stray_flit  = flit_valid && (state_q != OWNED);
    assign stray_grant = bank_grant_in && (state_q != REQ);
    assign error_d     = error_q | underflow | overflow | stray_flit | stray_grant;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        case (state_q)
            IDLE: begin
                // Requests are only looked at here; the latched winner is served even if it drops.
                if (|alloc_req) begin
                    winner_d = rr_pick;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bank_grant_in)
                    state_d = OWNED;
            end
            OWNED: begin
                if (flit_valid && flit_tail)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (count_d == full_count) begin
                    state_d = IDLE;
                    if (int'(winner_q) == num_vcs - 1)
                        ptr_d = '0;
                    else
                        ptr_d = winner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            count_q  <= full_count;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        alloc_gnt = '0;
        if (state_q == OWNED)
            alloc_gnt[winner_q] = 1'b1;
    end

    assign bank_req_out  = (state_q == REQ);
    assign shared_vc_out = (state_q == OWNED);
    assign credit_count  = count_q;
    assign error         = error_q;

`ifdef SHARED_CREDIT_BYPASS_EN
    assign shared_avail = (state_q == OWNED) && ((count_q != '0) || credit_for_shared_in);
`else
    assign shared_avail = (state_q == OWNED) && (count_q != '0);
`endif

endmodule

// File: tb/tb_shared_vc_credit_tracker.sv
// Bench for shared_vc_credit_tracker: directed vector table, hand-written corner sequences, random run vs reference model.
module tb_shared_vc_credit_tracker;

    localparam int NV = 4;
    localparam int SB = 8;
`ifdef SHARED_CREDIT_BYPASS_EN
    localparam int BYPASS = 1;
`else
    localparam int BYPASS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] alloc_req = 4'd0;
    logic       bank_grant_in = 1'b0;
    logic       flit_valid = 1'b0;
    logic       flit_tail = 1'b0;
    logic       credit_for_shared_in = 1'b0;
    logic       bank_req_out;
    logic [3:0] alloc_gnt;
    logic       shared_vc_out;
    logic       shared_avail;
    logic [3:0] credit_count;
    logic       error;

    always #5 clk = ~clk;

    shared_vc_credit_tracker #(.num_vcs(NV), .shared_buffer_size(SB)) dut (
        .clk                  (clk),
        .reset                (reset),
        .alloc_req            (alloc_req),
        .bank_grant_in        (bank_grant_in),
        .flit_valid           (flit_valid),
        .flit_tail            (flit_tail),
        .credit_for_shared_in (credit_for_shared_in),
        .bank_req_out         (bank_req_out),
        .alloc_gnt            (alloc_gnt),
        .shared_vc_out        (shared_vc_out),
        .shared_avail         (shared_avail),
        .credit_count         (credit_count),
        .error                (error)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       g, f, t, c;
        logic [3:0] e_gnt;
        logic       e_vc, e_breq, e_avail;
        logic [3:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] req, logic g, logic f, logic t, logic c,
                                logic [3:0] gnt, logic vc, logic breq, logic avail,
                                logic [3:0] cnt, logic err);
        vec_t v;
        v.rst = rst; v.req = req; v.g = g; v.f = f; v.t = t; v.c = c;
        v.e_gnt = gnt; v.e_vc = vc; v.e_breq = breq; v.e_avail = avail;
        v.e_cnt = cnt; v.e_err = err;
        return v;
    endfunction

    // Drive one cycle of inputs, then idle the inputs and compare the post-edge outputs.
    task automatic run_row(input vec_t v, input string tag);
        reset = v.rst; alloc_req = v.req; bank_grant_in = v.g;
        flit_valid = v.f; flit_tail = v.t; credit_for_shared_in = v.c;
        @(posedge clk); #1;
        reset = 1'b0; alloc_req = 4'd0; bank_grant_in = 1'b0;
        flit_valid = 1'b0; flit_tail = 1'b0; credit_for_shared_in = 1'b0;
        #1;
        check({tag, ".gnt"},   int'(alloc_gnt),     int'(v.e_gnt));
        check({tag, ".vc"},    int'(shared_vc_out), int'(v.e_vc));
        check({tag, ".breq"},  int'(bank_req_out),  int'(v.e_breq));
        check({tag, ".avail"}, int'(shared_avail),  int'(v.e_avail));
        check({tag, ".cnt"},   int'(credit_count),  int'(v.e_cnt));
        check({tag, ".err"},   int'(error),         int'(v.e_err));
    endtask

    // Reference model state: phase 0 idle, 1 requesting, 2 owning, 3 draining.
    int m_phase, m_win, m_ptr, m_cred, m_err;

    task automatic model_reset();
        m_phase = 0; m_win = 0; m_ptr = 0; m_cred = SB; m_err = 0;
    endtask

    task automatic model_step(input int rst, input int req, input int g, input int f,
                              input int t, input int c);
        int raw;
        if (rst != 0) begin
            model_reset();
            return;
        end
        if ((f != 0 && m_cred == 0 && c == 0) || (c != 0 && m_cred == SB && f == 0) ||
            (f != 0 && m_phase != 2) || (g != 0 && m_phase != 1))
            m_err = 1;
        raw = m_cred - f + c;
        m_cred = (raw < 0) ? 0 : ((raw > SB) ? SB : raw);
        case (m_phase)
            0: if (req != 0) begin
                for (int k = NV - 1; k >= 0; k--)
                    if (((req >> ((m_ptr + k) % NV)) & 1) != 0) m_win = (m_ptr + k) % NV;
                m_phase = 1;
            end
            1: if (g != 0) m_phase = 2;
            2: if (f != 0 && t != 0) m_phase = 3;
            default: if (m_cred == SB) begin
                m_phase = 0;
                m_ptr = (m_win + 1) % NV;
            end
        endcase
    endtask

    initial begin
        // Grant after request, 8 body flits drain the credits, 9th flit underflows.
        tbl.push_back(mk(1'b1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd8, 0));
        tbl.push_back(mk(1'b0, 4'b0100, 0, 0, 0, 0, 4'd0, 0, 1, 0, 4'd8, 0));
        tbl.push_back(mk(1'b0, 4'b0100, 1, 0, 0, 0, 4'b0100, 1, 0, 1, 4'd8, 0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1'b0, 4'd0, 0, 1, 0, 0, 4'b0100, 1, 0, (k != 8), 4'(8 - k), 0));
        tbl.push_back(mk(1'b0, 4'd0, 0, 1, 0, 0, 4'b0100, 1, 0, 0, 4'd0, 1));
        // Tail at count 5, drain holds until the last credit returns.
        tbl.push_back(mk(1'b1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd8, 0));
        tbl.push_back(mk(1'b0, 4'b0100, 0, 0, 0, 0, 4'd0, 0, 1, 0, 4'd8, 0));
        tbl.push_back(mk(1'b0, 4'd0, 1, 0, 0, 0, 4'b0100, 1, 0, 1, 4'd8, 0));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk(1'b0, 4'd0, 0, 1, 0, 0, 4'b0100, 1, 0, 1, 4'(8 - k), 0));
        tbl.push_back(mk(1'b0, 4'd0, 0, 1, 1, 0, 4'd0, 0, 0, 0, 4'd4, 0));
        tbl.push_back(mk(1'b0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd4, 0));
        for (int k = 5; k <= 8; k++)
            tbl.push_back(mk(1'b0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 4'(k), 0));
        // Back in IDLE with pointer at VC3: VC2 still wins, then flit+credit nets to zero.
        tbl.push_back(mk(1'b0, 4'b0100, 0, 0, 0, 0, 4'd0, 0, 1, 0, 4'd8, 0));
        tbl.push_back(mk(1'b0, 4'd0, 1, 0, 0, 0, 4'b0100, 1, 0, 1, 4'd8, 0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(1'b0, 4'd0, 0, 1, 0, 0, 4'b0100, 1, 0, 1, 4'(8 - k), 0));
        tbl.push_back(mk(1'b0, 4'd0, 0, 1, 0, 1, 4'b0100, 1, 0, 1, 4'd3, 0));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk(1'b0, 4'd0, 0, 1, 0, 0, 4'b0100, 1, 0, (k != 3), 4'(3 - k), 0));

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++)
            run_row(tbl[i], $sformatf("tbl%0d", i));

        // Credit arriving at count 0 in OWNED: same-cycle use only with the bypass build.
        credit_for_shared_in = 1'b1;
        #1;
        check("bypass.same_cycle", int'(shared_avail), BYPASS);
        @(posedge clk); #1;
        credit_for_shared_in = 1'b0;
        #1;
        check("bypass.next_cycle", int'(shared_avail), 1);
        check("bypass.cnt", int'(credit_count), 1);

        // Round-robin rotation with all VCs requesting.
        run_row(mk(1'b1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd8, 0), "rr.rst");
        for (int k = 0; k < 4; k++) begin
            run_row(mk(1'b0, 4'b1111, 0, 0, 0, 0, 4'd0, 0, 1, 0, 4'd8, 0), $sformatf("rr%0d.req", k));
            run_row(mk(1'b0, 4'b1111, 1, 0, 0, 0, 4'(1 << k), 1, 0, 1, 4'd8, 0), $sformatf("rr%0d.own", k));
            run_row(mk(1'b0, 4'b1111, 0, 1, 1, 0, 4'd0, 0, 0, 0, 4'd7, 0), $sformatf("rr%0d.tail", k));
            run_row(mk(1'b0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 4'd8, 0), $sformatf("rr%0d.ret", k));
        end

        // Stray grant in OWNED sets error; reset mid-ownership restores everything.
        run_row(mk(1'b0, 4'b0001, 0, 0, 0, 0, 4'd0, 0, 1, 0, 4'd8, 0), "mid.req");
        run_row(mk(1'b0, 4'd0, 1, 0, 0, 0, 4'b0001, 1, 0, 1, 4'd8, 0), "mid.own");
        run_row(mk(1'b0, 4'd0, 0, 1, 0, 0, 4'b0001, 1, 0, 1, 4'd7, 0), "mid.flit");
        run_row(mk(1'b0, 4'd0, 1, 0, 0, 0, 4'b0001, 1, 0, 1, 4'd7, 1), "mid.stray_grant");
        run_row(mk(1'b1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd8, 0), "mid.rst");
        run_row(mk(1'b0, 4'b0011, 0, 0, 0, 0, 4'd0, 0, 1, 0, 4'd8, 0), "mid.req2");
        run_row(mk(1'b0, 4'd0, 1, 0, 0, 0, 4'b0001, 1, 0, 1, 4'd8, 0), "mid.own2");

        // Credit at full count saturates and flags; flit outside OWNED still decrements.
        run_row(mk(1'b1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd8, 0), "sat.rst");
        run_row(mk(1'b0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 4'd8, 1), "sat.over");
        run_row(mk(1'b1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd8, 0), "stray.rst");
        run_row(mk(1'b0, 4'd0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 4'd7, 1), "stray.flit");

        // Random traffic against the reference model.
        run_row(mk(1'b1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd8, 0), "rnd.rst");
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r, q, g, f, t, c, e_avail;
            r = ($urandom_range(0, 63) == 0) ? 1 : 0;
            q = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0;
            g = (m_phase == 1) ? int'($urandom_range(0, 1)) : (($urandom_range(0, 59) == 0) ? 1 : 0);
            f = (m_phase == 2) ? int'($urandom_range(0, 1)) : (($urandom_range(0, 59) == 0) ? 1 : 0);
            t = ($urandom_range(0, 3) == 0) ? 1 : 0;
            c = (m_cred < SB) ? (($urandom_range(0, 2) == 0) ? 1 : 0) : (($urandom_range(0, 39) == 0) ? 1 : 0);
            reset = 1'(r); alloc_req = 4'(q); bank_grant_in = 1'(g);
            flit_valid = 1'(f); flit_tail = 1'(t); credit_for_shared_in = 1'(c);
            #1;
            e_avail = (m_phase == 2 && (m_cred != 0 || (BYPASS != 0 && c != 0))) ? 1 : 0;
            check($sformatf("rnd%0d.gnt", cyc),   int'(alloc_gnt),     (m_phase == 2) ? (1 << m_win) : 0);
            check($sformatf("rnd%0d.vc", cyc),    int'(shared_vc_out), (m_phase == 2) ? 1 : 0);
            check($sformatf("rnd%0d.breq", cyc),  int'(bank_req_out),  (m_phase == 1) ? 1 : 0);
            check($sformatf("rnd%0d.avail", cyc), int'(shared_avail),  e_avail);
            check($sformatf("rnd%0d.cnt", cyc),   int'(credit_count),  m_cred);
            check($sformatf("rnd%0d.err", cyc),   int'(error),         m_err);
            @(posedge clk);
            model_step(r, q, g, f, t, c);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
